// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits answer in the request cycle; misses and writes use a single-word RAM port.
module dcache #(
    parameter int SETS  = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             dmemREN,
    input  logic             dmemWEN,
    input  logic [31:0]      dmemaddr,
    input  logic [31:0]      dmemstore,
    output logic             dhit,
    output logic [31:0]      dmemload,
    output logic             ramREN,
    output logic             ramWEN,
    output logic [31:0]      ramaddr,
    output logic [31:0]      ramstore,
    input  logic [31:0]      ramload,
    input  logic             ramwait,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 30 - IW;

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, WDONE} state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [SETS-1:0] valid_r;
    logic [TW-1:0]   tag_r  [SETS];
    logic [31:0]     data_r [SETS];

    logic [IW-1:0]   index_s;
    logic [TW-1:0]   tag_s;
    logic            is_write_s;
    logic            is_read_s;
    logic            line_hit_s;
    logic            fill_s;
    logic            write_upd_s;
    logic            hit_inc_s;
    logic            miss_inc_s;
    logic            addr_unused_s;

    assign index_s       = dmemaddr[IW+1:2];
    assign tag_s         = dmemaddr[31:IW+2];
    assign addr_unused_s = ^dmemaddr[1:0];
    assign is_write_s    = dmemWEN;
    assign is_read_s     = dmemREN && !dmemWEN;
    assign line_hit_s    = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign fill_s        = (state_r == FETCH) && !ramwait;
    assign write_upd_s   = (state_r == WRITE) && !ramwait && line_hit_s;
    assign hit_inc_s     = (state_r == IDLE) && is_read_s && line_hit_s;
    assign miss_inc_s    = (state_r == IDLE) && is_read_s && !line_hit_s;

    // Next-state and output decode; strobes depend only on the registered state.
    always_comb begin
        state_next_s = state_r;
        dhit         = 1'b0;
        dmemload     = 32'd0;
        ramREN       = 1'b0;
        ramWEN       = 1'b0;
        ramaddr      = 32'd0;
        ramstore     = 32'd0;
        case (state_r)
            IDLE: begin
                if (is_write_s) begin
                    state_next_s = WRITE;
                end else if (is_read_s) begin
                    if (line_hit_s) begin
                        dhit     = 1'b1;
                        dmemload = data_r[index_s];
                    end else begin
                        state_next_s = FETCH;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            FETCH: begin
                ramREN  = 1'b1;
                ramaddr = {dmemaddr[31:2], 2'b00};
                if (!ramwait) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = FETCH;
                end
            end
            WRITE: begin
                ramWEN   = 1'b1;
                ramaddr  = {dmemaddr[31:2], 2'b00};
                ramstore = dmemstore;
                if (!ramwait) begin
                    state_next_s = WDONE;
                end else begin
                    state_next_s = WRITE;
                end
            end
            WDONE: begin
                dhit         = 1'b1;
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register, valid bits and statistics counters.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            valid_r    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state_r <= state_next_s;
            if (fill_s) begin
                valid_r[index_s] <= 1'b1;
            end
            if (hit_inc_s) begin
                hit_count <= hit_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (miss_inc_s) begin
                miss_count <= miss_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Line tag/data storage; a reset edge suppresses any pending update.
    always_ff @(posedge CLK) begin
        if (!RST && fill_s) begin
            tag_r[index_s]  <= tag_s;
            data_r[index_s] <= ramload;
        end else if (!RST && write_upd_s) begin
            data_r[index_s] <= dmemstore;
        end
    end
endmodule

// File: tb/tb_dcache.sv
// Scoreboard bench for dcache: a small wait-state RAM model plus per-feature test tasks.
module tb_dcache;
    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        dmemREN = 1'b0;
    logic        dmemWEN = 1'b0;
    logic [31:0] dmemaddr = 32'd0;
    logic [31:0] dmemstore = 32'd0;
    logic        dhit;
    logic [31:0] dmemload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic        ramwait;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int total = 0;
    int bad = 0;

    logic [31:0] mem_arr [256];
    int          ram_w = 0;
    int          wait_cnt = 0;

    typedef struct {
        logic [31:0] load;
        int          lat;
        int          nren;
        int          nwen;
    } exp_t;
    exp_t expq[$];

    dcache #(.SETS(16), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramwait(ramwait),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 CLK = ~CLK;

    assign ramwait = (ramREN || ramWEN) && (wait_cnt < ram_w);
    assign ramload = mem_arr[ramaddr[9:2]];

    // RAM wait-state counter: holds ramwait high for ram_w cycles of each transfer.
    always @(posedge CLK) begin
        if ((ramREN || ramWEN) && ramwait) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
    end

    // Present one request and observe until dhit (bounded); RAM writes land in mem_arr.
    task automatic do_req(input logic ren, input logic wen, input logic [31:0] addr,
                          input logic [31:0] store, input int w,
                          output int lat, output logic [31:0] load, output int nren,
                          output int nwen, output int both, output logic [31:0] waddr,
                          output logic [31:0] wdata);
        int cyc;
        bit done;
        cyc = 0; done = 0; lat = -1; load = 32'hx; nren = 0; nwen = 0; both = 0;
        waddr = 32'd0; wdata = 32'd0;
        @(posedge CLK); #1;
        ram_w = w; dmemREN = ren; dmemWEN = wen; dmemaddr = addr; dmemstore = store;
        while (!done && cyc < 40) begin
            @(negedge CLK);
            if (ramREN) nren++;
            if (ramWEN) begin
                nwen++;
                waddr = ramaddr;
                wdata = ramstore;
                if (!ramwait) mem_arr[ramaddr[9:2]] = ramstore;
            end
            if (ramREN && ramWEN) both++;
            if (dhit) begin
                done = 1;
                lat = cyc;
                load = dmemload;
            end else begin
                cyc++;
            end
        end
        @(posedge CLK); #1;
        dmemREN = 1'b0; dmemWEN = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        total++; if (dhit !== 1'b0) begin bad++; $display("FAIL reset_dhit got=%0b want=0", dhit); end
        total++; if (dmemload !== 32'd0) begin bad++; $display("FAIL reset_dmemload got=%h want=0", dmemload); end
        total++; if (ramREN !== 1'b0) begin bad++; $display("FAIL reset_ramREN got=%0b want=0", ramREN); end
        total++; if (ramWEN !== 1'b0) begin bad++; $display("FAIL reset_ramWEN got=%0b want=0", ramWEN); end
        total++; if (ramaddr !== 32'd0) begin bad++; $display("FAIL reset_ramaddr got=%h want=0", ramaddr); end
        total++; if (ramstore !== 32'd0) begin bad++; $display("FAIL reset_ramstore got=%h want=0", ramstore); end
        total++; if (hit_count !== 32'd0) begin bad++; $display("FAIL reset_hits got=%0d want=0", hit_count); end
        total++; if (miss_count !== 32'd0) begin bad++; $display("FAIL reset_misses got=%0d want=0", miss_count); end
    endtask

    // Run one request with the given expectation pushed first, then pop and compare.
    task automatic run_checked(input string name, input logic ren, input logic wen,
                               input logic [31:0] addr, input logic [31:0] store, input int w,
                               input logic [31:0] exp_load, input int exp_lat,
                               input int exp_nren, input int exp_nwen,
                               input logic [31:0] exp_waddr, input logic [31:0] exp_wdata);
        int lat, nren, nwen, both;
        logic [31:0] load, waddr, wdata;
        exp_t e;
        expq.push_back('{load: exp_load, lat: exp_lat, nren: exp_nren, nwen: exp_nwen});
        do_req(ren, wen, addr, store, w, lat, load, nren, nwen, both, waddr, wdata);
        e = expq.pop_front();
        total++; if (lat !== e.lat) begin bad++; $display("FAIL %s_latency got=%0d want=%0d", name, lat, e.lat); end
        total++; if (load !== e.load) begin bad++; $display("FAIL %s_dmemload got=%h want=%h", name, load, e.load); end
        total++; if (nren !== e.nren) begin bad++; $display("FAIL %s_ramREN_cycles got=%0d want=%0d", name, nren, e.nren); end
        total++; if (nwen !== e.nwen) begin bad++; $display("FAIL %s_ramWEN_cycles got=%0d want=%0d", name, nwen, e.nwen); end
        total++; if (both !== 0) begin bad++; $display("FAIL %s_strobe_overlap got=%0d want=0", name, both); end
        if (e.nwen > 0) begin
            total++; if (waddr !== exp_waddr) begin bad++; $display("FAIL %s_ramaddr got=%h want=%h", name, waddr, exp_waddr); end
            total++; if (wdata !== exp_wdata) begin bad++; $display("FAIL %s_ramstore got=%h want=%h", name, wdata, exp_wdata); end
        end
    endtask

    task automatic test_read_miss();
        run_checked("miss40", 1'b1, 1'b0, 32'h40, 32'd0, 2, 32'hDEADBEEF, 4, 3, 0, 32'd0, 32'd0);
        total++; if (miss_count !== 32'd1) begin bad++; $display("FAIL miss40_misses got=%0d want=1", miss_count); end
        total++; if (hit_count !== 32'd1) begin bad++; $display("FAIL miss40_hits got=%0d want=1", hit_count); end
    endtask

    task automatic test_read_hit();
        run_checked("hit40", 1'b1, 1'b0, 32'h40, 32'd0, 2, 32'hDEADBEEF, 0, 0, 0, 32'd0, 32'd0);
        total++; if (hit_count !== 32'd2) begin bad++; $display("FAIL hit40_hits got=%0d want=2", hit_count); end
    endtask

    task automatic test_write_hit();
        run_checked("wr40", 1'b0, 1'b1, 32'h40, 32'h12345678, 0, 32'd0, 2, 0, 1, 32'h40, 32'h12345678);
        run_checked("rd40_after_wr", 1'b1, 1'b0, 32'h40, 32'd0, 0, 32'h12345678, 0, 0, 0, 32'd0, 32'd0);
    endtask

    task automatic test_no_allocate();
        run_checked("wr80", 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 1, 32'd0, 3, 0, 2, 32'h80, 32'hCAFEF00D);
        run_checked("rd40_kept", 1'b1, 1'b0, 32'h40, 32'd0, 0, 32'h12345678, 0, 0, 0, 32'd0, 32'd0);
        run_checked("rd80_miss", 1'b1, 1'b0, 32'h80, 32'd0, 0, 32'hCAFEF00D, 2, 1, 0, 32'd0, 32'd0);
        total++; if (miss_count !== 32'd2) begin bad++; $display("FAIL rd80_misses got=%0d want=2", miss_count); end
    endtask

    task automatic test_ren_wen();
        run_checked("renwen44", 1'b1, 1'b1, 32'h44, 32'h55AA55AA, 1, 32'd0, 3, 0, 2, 32'h44, 32'h55AA55AA);
        total++; if (mem_arr[17] !== 32'h55AA55AA) begin bad++; $display("FAIL renwen44_ram got=%h want=55aa55aa", mem_arr[17]); end
    endtask

    task automatic test_reset_mid_fetch();
        @(posedge CLK); #1;
        ram_w = 10; dmemREN = 1'b1; dmemWEN = 1'b0; dmemaddr = 32'h40;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        total++; if (ramREN !== 1'b1) begin bad++; $display("FAIL midfetch_ramREN got=%0b want=1", ramREN); end
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        RST = 1'b0; dmemREN = 1'b0;
        @(negedge CLK);
        total++; if (ramREN !== 1'b0) begin bad++; $display("FAIL abort_ramREN got=%0b want=0", ramREN); end
        total++; if (miss_count !== 32'd0) begin bad++; $display("FAIL abort_misses got=%0d want=0", miss_count); end
        run_checked("rd40_after_rst", 1'b1, 1'b0, 32'h40, 32'd0, 1, 32'h12345678, 3, 2, 0, 32'd0, 32'd0);
        total++; if (miss_count !== 32'd1) begin bad++; $display("FAIL rst_misses got=%0d want=1", miss_count); end
        total++; if (hit_count !== 32'd1) begin bad++; $display("FAIL rst_hits got=%0d want=1", hit_count); end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[16] = 32'hDEADBEEF;
        mem_arr[32] = 32'h11111111;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_no_allocate();
        test_ren_wen();
        test_reset_mid_fetch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache.md
# dcache

Direct-mapped, write-through, no-write-allocate data cache that is the responder on the memory stage's data port. It accepts single-word read/write requests (dmemREN/dmemWEN/dmemaddr/dmemstore) and answers with dhit/dmemload. Read hits complete in the request cycle. Misses and all writes go to a single-word RAM port with a wait handshake.

## Interface
Parameters:
- SETS, 16, number of one-word lines (power of 2); index width IW = log2(SETS)
- CNT_W, 32, width of the hit/miss statistics counters

Ports. One clock; reset is synchronous and active-high.
- CLK  in  1  clock; all state changes on the rising edge
- RST  in  1  synchronous active-high reset
- dmemREN  in  1  read request, held until dhit
- dmemWEN  in  1  write request, held until dhit
- dmemaddr  in  32  byte address; bits [1:0] ignored
- dmemstore  in  32  write data
- dhit  out  1  request complete this cycle
- dmemload  out  32  read data, valid when dhit && dmemREN
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM word address, {dmemaddr[31:2], 2'b00}
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when ramREN && !ramwait
- ramwait  in  1  RAM busy; a transfer completes in the first cycle ramwait is low while a strobe is high
- hit_count  out  CNT_W  read hits since reset
- miss_count  out  CNT_W  read misses since reset

## Operation
- Address split: index = dmemaddr[IW+1:2], tag = dmemaddr[31:IW+2]. Each line holds valid, tag and one data word.
- Request priority: if dmemWEN and dmemREN are both high, the request is treated as a write.
- FSM states: IDLE, FETCH, WRITE, WDONE.
- IDLE, read, line valid and tag match: dhit=1 and dmemload=line data combinationally. hit_count increments at the edge. State stays IDLE.
- IDLE, read, miss: dhit=0. miss_count increments at the edge. Go to FETCH.
- IDLE, write: dhit=0. Go to WRITE.
- FETCH: ramREN=1, ramaddr from the current dmemaddr. On the edge where ramwait=0, write ramload into the line (valid=1, tag) and go to IDLE. The retried read then hits.
- WRITE: ramWEN=1, ramstore=dmemstore. On the edge where ramwait=0:
  - if the line is valid and the tag matches, overwrite the line data with dmemstore; otherwise the line is unchanged (no allocate).
  - go to WDONE.
- WDONE: dhit=1 for exactly one cycle, then go to IDLE. If the requester still holds dmemWEN in the following cycle, the write is reissued; this is idempotent and allowed.
- If the request drops mid-FETCH, the fill still completes and the line is still written. No dhit is produced.
- If the request drops mid-WRITE, the RAM write still completes. dhit still pulses in WDONE; the requester ignores it.
- dmemload = 0 whenever dhit=0 or the request is a write.
- Counters wrap modulo 2^CNT_W.

## Timing
- Reset (RST=1 at an edge): state=IDLE, all valid bits=0, hit_count=0, miss_count=0.
  - Outputs after reset: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, dhit=0, dmemload=0.
  - Line data and tags need no reset.
- Reset mid-FETCH or mid-WRITE aborts the transfer: strobes drop the next cycle and no line is updated.
- ramaddr and ramstore are 0 in IDLE and WDONE.
- Read hit: latency 0; dhit is asserted in the same cycle the request is presented.
- Read miss with RAM wait of W cycles (ramwait high W cycles, then low):
  - FETCH lasts W+1 cycles.
  - dhit is asserted in cycle W+2 after the request, counting the request cycle as cycle 0.
- Write with RAM wait W: WRITE lasts W+1 cycles, and dhit is asserted in the WDONE cycle, cycle W+2.
- ramREN and ramWEN are never high at the same time. Both are registered-state decodes, with no combinational path from dmem* inputs to the strobes.
- dhit and dmemload are combinational from the registered state and the dmem* inputs.

## Test plan
- Reset, then read 0x40 with W=2 (ramload=0xDEADBEEF): ramREN high for 3 cycles; dhit=1 in cycle 4 with dmemload=0xDEADBEEF; miss_count=1, hit_count=1.
- Read 0x40 again: dhit=1 in the same cycle, dmemload=0xDEADBEEF, no ramREN; hit_count=2.
- Write 0x40 with dmemstore=0x12345678 and W=0: ramWEN for 1 cycle with ramaddr=0x40 and ramstore=0x12345678; dhit in the next cycle. A following read of 0x40 hits and returns 0x12345678.
- Write 0x80 (same index as 0x40 when SETS=16, different tag): RAM write occurs. A following read of 0x40 still hits with 0x12345678; a read of 0x80 misses.
- Assert REN and WEN together at 0x44: write path is taken, ramWEN=1, ramREN=0 throughout.
- Raise RST during FETCH: ramREN=0 the next cycle; a read of the same address misses again with miss_count restarting from 1.
